// File: rtl/outport_uart_tx_if.sv
// Write-side handshake and serial/status outputs of the outport UART transmitter.
// The bench drives through master; the transmitter sits on slave.
interface outport_uart_tx_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        tx;
    logic        busy;
    logic        empty;
    logic        full;
    logic        overflow;

    modport master (
        output wr_valid,
        output wr_data,
        input  tx,
        input  busy,
        input  empty,
        input  full,
        input  overflow
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output tx,
        output busy,
        output empty,
        output full,
        output overflow
    );
endinterface

// File: rtl/outport_uart_tx.sv
// Buffers 32-bit outport words in a small FIFO and sends each one as four
// UART 8N1 frames, least significant byte first, on a registered tx line.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               clr,
    outport_uart_tx_if.slave   bus
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        shifter_q, shifter_d;
    logic               tx_q, tx_d;

    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty_q, full_q, overflow_q;
    logic               push, pop;
    logic [31:0]        rd_words [FIFO_DEPTH];

    // A write to a full FIFO is always dropped, even if a pop frees a slot this cycle.
    assign push = bus.wr_valid && !full_q;

    // One register per FIFO entry, each with its own write enable.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [31:0] word_q;
        always_ff @(posedge clk) begin
            if (!clr && push && (wptr_q == PTR_W'(gi))) begin
                word_q <= bus.wr_data;
            end
        end
        assign rd_words[gi] = word_q;
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shifter_d  = shifter_q;
        pop        = 1'b0;
        tx_d       = 1'b1;

        if (state_q != IDLE) begin
            baud_d = (baud_q == BAUD_LAST) ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop        = 1'b1;
                    shifter_d  = rd_words[rptr_q];
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx follows the current state, so it lags each state change by one cycle.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shifter_q[{byte_idx_q, bit_idx_q}];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shifter_q  <= '0;
            tx_q       <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shifter_q  <= shifter_d;
            tx_q       <= tx_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CNT_FULL);
            overflow_q <= overflow_q | (bus.wr_valid & full_q);
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;

endmodule
